// File: rtl/core_sequencer_pkg.sv
// Shared control definitions for the multi-cycle core sequencer:
// state encodings, datapath mux selects and the control strobe bundle.
package core_sequencer_pkg;

    // Sequencer states; encodings are visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } sequencer_state_t;

    // Program-counter next-value select.
    localparam logic PC_SRC_PLUS4 = 1'b0;
    localparam logic PC_SRC_ALU   = 1'b1;

    // Memory address select.
    localparam logic MEM_ADDR_PC  = 1'b0;
    localparam logic MEM_ADDR_ALU = 1'b1;

    // Control strobes and status flags produced by the sequencer each cycle.
    typedef struct packed {
        logic memory_request;
        logic memory_write;
        logic memory_address_source;
        logic instruction_register_load;
        logic register_file_write_enable;
        logic program_counter_write_enable;
        logic program_counter_source;
        logic halted;
        logic trap;
    } control_t;

    // Quiet bundle: no strobes, no status.
    localparam control_t CONTROL_NONE = '0;

    // Instruction touches data memory (load or store).
    function automatic logic is_memory_op(input logic mem_read, input logic mem_write);
        return mem_read | mem_write;
    endfunction

    // A load and a store at once cannot be executed on a single port.
    function automatic logic is_conflicting_op(input logic mem_read, input logic mem_write);
        return mem_read & mem_write;
    endfunction

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// memory_wait_timer: counts cycles a memory request waits for ready.
// Saturating counter with synchronous clear; 'expired' flags the last
// allowed wait cycle so the caller can trap on that same edge.
// MEMORY_TIMEOUT = 0 disables expiry entirely.
module memory_wait_timer #(
    parameter int MEMORY_TIMEOUT = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_enable,
    output logic expired
);

    localparam int LIMIT_I = (MEMORY_TIMEOUT > 0) ? MEMORY_TIMEOUT - 1 : 0;
    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT     = LIMIT_I[TIMEOUT_WIDTH-1:0];
    localparam logic [TIMEOUT_WIDTH-1:0] COUNT_MAX = '1;

    logic [TIMEOUT_WIDTH-1:0] count_q;
    logic [TIMEOUT_WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise count up and hold at the top value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is reached when the count sits on the final allowed wait cycle.
    always_comb begin
        expired = (MEMORY_TIMEOUT != 0) && (count_q == LIMIT);
    end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the tiny RISC-V core.
// Walks FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK over one shared
// memory port and turns the decoder's level outputs into one-cycle strobes.
// Optional: define CORE_SEQUENCER_RETIRE_COUNTER_EN to add the
// instructions_retired counter output.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int MEMORY_TIMEOUT = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       memory_ready,
    input  logic       decoded_register_write_enable,
    input  logic       decoded_memory_write_enable,
    input  logic       decoded_memory_read,
    input  logic       decoded_branch,
    input  logic       decoded_jump,
    input  logic       decoded_invalid,
    input  logic       halt_request,
    output logic       memory_request,
    output logic       memory_write,
    output logic       memory_address_source,
    output logic       instruction_register_load,
    output logic       register_file_write_enable,
    output logic       program_counter_write_enable,
    output logic       program_counter_source,
    output logic [2:0] state,
    output logic       halted,
    output logic       trap
`ifdef CORE_SEQUENCER_RETIRE_COUNTER_EN
    ,
    output logic [31:0] instructions_retired
`endif
);

    sequencer_state_t state_q;
    sequencer_state_t state_d;
    control_t         ctrl;

    logic timer_active;
    logic timer_clear;
    logic timer_count_enable;
    logic timer_expired;

    logic memory_op;
    logic conflicting_op;

    // Classify the decoded instruction once for the next-state logic.
    always_comb begin
        memory_op      = is_memory_op(decoded_memory_read, decoded_memory_write_enable);
        conflicting_op = is_conflicting_op(decoded_memory_read, decoded_memory_write_enable);
    end

    // The timer only runs while a memory request is outstanding; holding it
    // clear everywhere else guarantees a zero count on entry to FETCH/MEMORY.
    always_comb begin
        timer_active       = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
        timer_clear        = !timer_active;
        timer_count_enable = timer_active && !memory_ready;
    end

    memory_wait_timer #(
        .MEMORY_TIMEOUT (MEMORY_TIMEOUT),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_wait_timer (
        .clock        (clock),
        .reset        (reset),
        .clear        (timer_clear),
        .count_enable (timer_count_enable),
        .expired      (timer_expired)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory_ready beats the timeout in the waiting states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!halt_request) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (memory_ready)       state_d = ST_DECODE;
                else if (timer_expired) state_d = ST_TRAP;
            end
            ST_DECODE: begin
                if (decoded_invalid || conflicting_op) state_d = ST_TRAP;
                else                                   state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (memory_op) state_d = ST_MEMORY;
                else           state_d = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                if (memory_ready)       state_d = ST_WRITEBACK;
                else if (timer_expired) state_d = ST_TRAP;
            end
            ST_WRITEBACK: begin
                if (halt_request) state_d = ST_IDLE;
                else              state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    // Output decode; reset forces the idle bundle so an in-flight request
    // drops in the same cycle reset is seen.
    always_comb begin
        ctrl = CONTROL_NONE;
        if (reset) begin
            ctrl.halted = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ctrl.halted = 1'b1;
                end
                ST_FETCH: begin
                    ctrl.memory_request            = 1'b1;
                    ctrl.memory_address_source     = MEM_ADDR_PC;
                    ctrl.memory_write              = 1'b0;
                    ctrl.instruction_register_load = memory_ready;
                end
                ST_MEMORY: begin
                    ctrl.memory_request        = 1'b1;
                    ctrl.memory_address_source = MEM_ADDR_ALU;
                    ctrl.memory_write          = decoded_memory_write_enable;
                end
                ST_WRITEBACK: begin
                    ctrl.register_file_write_enable   = decoded_register_write_enable;
                    ctrl.program_counter_write_enable = 1'b1;
                    ctrl.program_counter_source       = (decoded_branch || decoded_jump)
                                                        ? PC_SRC_ALU : PC_SRC_PLUS4;
                end
                ST_TRAP: begin
                    ctrl.trap = 1'b1;
                end
                default: begin
                    ctrl = CONTROL_NONE;
                end
            endcase
        end
    end

    assign memory_request               = ctrl.memory_request;
    assign memory_write                 = ctrl.memory_write;
    assign memory_address_source        = ctrl.memory_address_source;
    assign instruction_register_load    = ctrl.instruction_register_load;
    assign register_file_write_enable   = ctrl.register_file_write_enable;
    assign program_counter_write_enable = ctrl.program_counter_write_enable;
    assign program_counter_source       = ctrl.program_counter_source;
    assign halted                       = ctrl.halted;
    assign trap                         = ctrl.trap;
    assign state                        = state_q;

`ifdef CORE_SEQUENCER_RETIRE_COUNTER_EN
    logic [31:0] instructions_retired_q;
    logic [31:0] instructions_retired_d;

    // Every WRITEBACK cycle retires one instruction; wraps naturally.
    always_comb begin
        instructions_retired_d = instructions_retired_q;
        if (state_q == ST_WRITEBACK) begin
            instructions_retired_d = instructions_retired_q + 32'd1;
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            instructions_retired_q <= '0;
        end else begin
            instructions_retired_q <= instructions_retired_d;
        end
    end

    assign instructions_retired = instructions_retired_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: instruction-level model expands each directed
// instruction into its expected per-cycle outputs; one process compares.
module tb_core_sequencer;

    localparam int TO = 4;

    logic clock = 1'b0;
    logic reset, memory_ready, halt_request;
    logic d_rwe, d_mwe, d_mrd, d_br, d_jmp, d_inv;
    logic memory_request, memory_write, memory_address_source, instruction_register_load;
    logic register_file_write_enable, program_counter_write_enable, program_counter_source;
    logic [2:0] state;
    logic halted, trap;
`ifdef CORE_SEQUENCER_RETIRE_COUNTER_EN
    logic [31:0] instructions_retired;
`endif

    always #5 clock = ~clock;

    core_sequencer #(.MEMORY_TIMEOUT(TO), .TIMEOUT_WIDTH(8)) dut (
        .clock                         (clock),
        .reset                         (reset),
        .memory_ready                  (memory_ready),
        .decoded_register_write_enable (d_rwe),
        .decoded_memory_write_enable   (d_mwe),
        .decoded_memory_read           (d_mrd),
        .decoded_branch                (d_br),
        .decoded_jump                  (d_jmp),
        .decoded_invalid               (d_inv),
        .halt_request                  (halt_request),
        .memory_request                (memory_request),
        .memory_write                  (memory_write),
        .memory_address_source         (memory_address_source),
        .instruction_register_load     (instruction_register_load),
        .register_file_write_enable    (register_file_write_enable),
        .program_counter_write_enable  (program_counter_write_enable),
        .program_counter_source        (program_counter_source),
        .state                         (state),
        .halted                        (halted),
        .trap                          (trap)
`ifdef CORE_SEQUENCER_RETIRE_COUNTER_EN
        ,
        .instructions_retired          (instructions_retired)
`endif
    );

    typedef struct packed {
        logic [2:0] st;
        logic mreq, mwr, masrc, irl, rfwe, pcwe, pcsrc, hlt, trp;
    } obs_t;

    obs_t  exp_o, exp_m, act;
    bit    exp_on = 1'b0, ret_on = 1'b0;
    int    checks = 0, passes = 0;
    string tag = "none";
    int unsigned model_ret = 0;
    obs_t  log_q[$];

    function automatic obs_t o(input logic [2:0] st, input logic mreq, mwr, masrc, irl,
                               rfwe, pcwe, pcsrc, hlt, trp);
        return {st, mreq, mwr, masrc, irl, rfwe, pcwe, pcsrc, hlt, trp};
    endfunction

    // Count logged cycles from index a whose masked fields equal v.
    function automatic int cnt(input int a, input obs_t m, input obs_t v);
        int n = 0;
        for (int i = a; i < log_q.size(); i++)
            if ((log_q[i] & m) == (v & m)) n++;
        return n;
    endfunction

    task automatic chk(input string n, input longint got, input longint want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d want %0d", n, got, want);
    endtask

    // Per-cycle compare against the model's expectation.
    always @(negedge clock) begin
        if (exp_on) begin
            act = o(state, memory_request, memory_write, memory_address_source,
                    instruction_register_load, register_file_write_enable,
                    program_counter_write_enable, program_counter_source, halted, trap);
            log_q.push_back(act);
            checks++;
            if (((act ^ exp_o) & exp_m) == '0) passes++;
            else $display("FAIL %s: outputs got %h want %h care %h t=%0t",
                          tag, act, exp_o, exp_m, $time);
`ifdef CORE_SEQUENCER_RETIRE_COUNTER_EN
            if (ret_on) begin
                checks++;
                if (instructions_retired == model_ret) passes++;
                else $display("FAIL %s retired: got %0d want %0d", tag,
                              instructions_retired, model_ret);
            end
`endif
        end
    end

    // Expected outputs for one cycle; mux selects only matter where used.
    task automatic ex(input obs_t e, input string t);
        exp_o = e;
        exp_m = '1;
        if (!(e.st == 3'd1 || e.st == 3'd4)) exp_m.masrc = 1'b0;
        if (e.st != 3'd5) exp_m.pcsrc = 1'b0;
        tag = t; ret_on = 1'b1; exp_on = 1'b1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; model_ret = 0; memory_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            ex(o(0,0,0,0,0,0,0,0,1,0), "reset");
            exp_m.st = '0; exp_m.trp = 1'b0; ret_on = 1'b0;
            step();
        end
        reset = 1'b0;
    endtask

    task automatic idle(input logic h);
        halt_request = h;
        ex(o(0,0,0,0,0,0,0,0,1,0), "idle");
        step();
    endtask

    task automatic trap_run(input int n);
        for (int i = 0; i < n; i++) begin
            halt_request = i[0];
            ex(o(6,0,0,0,0,0,0,0,0,1), "trap");
            step();
        end
    endtask

    // One instruction from FETCH onward: fw/mw wait cycles in FETCH/MEMORY.
    task automatic run_instr(input logic rwe, mwe, mrd, br, jmp, inv,
                             input int fw, input int mw, input logic hlt, input int trap_n);
        d_rwe = rwe; d_mwe = mwe; d_mrd = mrd; d_br = br; d_jmp = jmp; d_inv = inv;
        halt_request = hlt;
        for (int i = 0; i < fw && i < TO; i++) begin
            memory_ready = 1'b0; ex(o(1,1,0,0,0,0,0,0,0,0), "fetch_wait"); step();
        end
        memory_ready = 1'b1;
        if (fw >= TO) begin trap_run(trap_n); return; end
        ex(o(1,1,0,0,1,0,0,0,0,0), "fetch"); step();
        ex(o(2,0,0,0,0,0,0,0,0,0), "decode"); step();
        if (inv || (mrd && mwe)) begin trap_run(trap_n); return; end
        ex(o(3,0,0,0,0,0,0,0,0,0), "execute"); step();
        if (mrd || mwe) begin
            for (int i = 0; i < mw && i < TO; i++) begin
                memory_ready = 1'b0; ex(o(4,1,mwe,1,0,0,0,0,0,0), "mem_wait"); step();
            end
            memory_ready = 1'b1;
            if (mw >= TO) begin trap_run(trap_n); return; end
            ex(o(4,1,mwe,1,0,0,0,0,0,0), "memory"); step();
        end
        ex(o(5,0,0,0,0,rwe,1,br|jmp,0,0), "writeback"); step();
        model_ret++;
    endtask

    initial begin
        int s;
        logic [17:0] seq;
        memory_ready = 1'b1; halt_request = 1'b0;
        d_rwe = 0; d_mwe = 0; d_mrd = 0; d_br = 0; d_jmp = 0; d_inv = 0;
        do_reset(2);

        // ADD with ready tied high, then a load with 1 fetch wait and 3 memory waits.
        log_q.delete();
        idle(1'b0);
        run_instr(1,0,0,0,0,0, 0,0, 0, 0);
        s = log_q.size();
        run_instr(1,0,1,0,0,0, 1,3, 0, 0);
        chk("add_log_len", s, 5);
        if (log_q.size() >= 6) begin
            seq = {log_q[0].st, log_q[1].st, log_q[2].st, log_q[3].st, log_q[4].st, log_q[5].st};
            chk("add_state_seq", seq, 18'o012351);
            chk("add_pcsrc", log_q[4].pcsrc, 0);
        end
        chk("add_rfwe_once", cnt(0, o(0,0,0,0,0,1,0,0,0,0), o(0,0,0,0,0,1,0,0,0,0))
                              - cnt(s, o(0,0,0,0,0,1,0,0,0,0), o(0,0,0,0,0,1,0,0,0,0)), 1);
        chk("load_mem_addr_cycles", cnt(s, o(7,0,1,1,0,0,0,0,0,0), o(4,0,0,1,0,0,0,0,0,0)), 4);
        chk("load_wb_rfwe", cnt(s, o(7,0,0,0,0,1,0,0,0,0), o(5,0,0,0,0,1,0,0,0,0)), 1);

        // Store: memory_write only in MEMORY, no register write.
        s = log_q.size();
        run_instr(0,1,0,0,0,0, 0,1, 0, 0);
        chk("store_mwr_cycles", cnt(s, o(0,0,1,0,0,0,0,0,0,0), o(0,0,1,0,0,0,0,0,0,0)), 2);
        chk("store_mwr_in_mem", cnt(s, o(7,0,1,0,0,0,0,0,0,0), o(4,0,1,0,0,0,0,0,0,0)), 2);
        chk("store_no_rfwe", cnt(s, o(0,0,0,0,0,1,0,0,0,0), o(0,0,0,0,0,1,0,0,0,0)), 0);

        // Taken branch.
        s = log_q.size();
        run_instr(0,0,0,1,0,0, 0,0, 0, 0);
        chk("branch_pc_alu_once", cnt(s, o(0,0,0,0,0,0,1,1,0,0), o(0,0,0,0,0,0,1,1,0,0)), 1);

        // JAL with halt held through the instruction: completes, then IDLE.
        s = log_q.size();
        run_instr(1,0,0,0,1,0, 0,0, 1, 0);
        idle(1'b1); idle(1'b1); idle(1'b1); idle(1'b0);
        chk("halt_no_split", cnt(s, o(7,0,0,0,0,0,0,0,0,0), o(5,0,0,0,0,0,0,0,0,0)), 1);
        chk("halt_idle_cycles", cnt(s, o(7,0,0,0,0,0,0,0,1,0), o(0,0,0,0,0,0,0,0,1,0)), 4);

        // Ready arrives on the last allowed fetch wait: ready wins.
        s = log_q.size();
        run_instr(1,0,0,0,0,0, 3,0, 0, 0);
        chk("fetch_ready_at_limit", cnt(s, o(0,0,0,0,1,0,0,0,0,0), o(0,0,0,0,1,0,0,0,0,0)), 1);

        // Reset during a memory wait drops the request at once.
        d_mrd = 1; d_rwe = 1; d_mwe = 0; d_br = 0; d_jmp = 0; d_inv = 0; halt_request = 0;
        ex(o(1,1,0,0,1,0,0,0,0,0), "fetch"); step();
        ex(o(2,0,0,0,0,0,0,0,0,0), "decode"); step();
        ex(o(3,0,0,0,0,0,0,0,0,0), "execute"); step();
        memory_ready = 1'b0; ex(o(4,1,0,1,0,0,0,0,0,0), "mem_wait"); step();
        do_reset(1);
        memory_ready = 1'b0;
        idle(1'b0);

        // ADD, then fetch timeout: trapped instruction must not retire.
        run_instr(1,0,0,0,0,0, 0,0, 0, 0);
        s = log_q.size();
        run_instr(1,0,0,0,0,0, TO,0, 0, 6);
        chk("fetch_timeout_waits", cnt(s, o(7,0,0,0,0,0,0,0,0,0), o(1,0,0,0,0,0,0,0,0,0)), 4);
        chk("fetch_timeout_trap", cnt(s, o(7,0,0,0,0,0,0,0,0,1), o(6,0,0,0,0,0,0,0,0,1)), 6);
`ifdef CORE_SEQUENCER_RETIRE_COUNTER_EN
        chk("retired_after_trap", instructions_retired, 1);
`endif

        // Invalid instruction: sticky trap for 100 cycles, reset recovers.
        do_reset(1);
        idle(1'b0);
        s = log_q.size();
        run_instr(0,0,0,0,0,1, 0,0, 0, 100);
        chk("invalid_trap_sticky", cnt(s, o(7,0,0,0,0,0,0,0,0,1), o(6,0,0,0,0,0,0,0,0,1)), 100);
        do_reset(1);
        idle(1'b0);
        s = log_q.size();
        run_instr(1,0,0,0,0,0, 0,0, 0, 0);
        chk("recover_fetch", (log_q.size() > s) ? log_q[s].st : 7, 1);

        // Load and store together traps in DECODE.
        s = log_q.size();
        run_instr(1,1,1,0,0,0, 0,0, 0, 5);
        chk("ldst_conflict_trap", cnt(s, o(7,0,0,0,0,0,0,0,0,1), o(6,0,0,0,0,0,0,0,0,1)), 5);

        // Memory-phase timeout.
        do_reset(1);
        idle(1'b0);
        s = log_q.size();
        run_instr(1,0,1,0,0,0, 0,TO, 0, 3);
        chk("mem_timeout_waits", cnt(s, o(7,0,0,0,0,0,0,0,0,0), o(4,0,0,0,0,0,0,0,0,0)), 4);
        chk("mem_timeout_trap", cnt(s, o(7,0,0,0,0,0,0,0,0,1), o(6,0,0,0,0,0,0,0,0,1)), 3);

        do_reset(1);
        idle(1'b1);
        exp_on = 1'b0;
        @(posedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
